// File: rtl/display_scan_ctrl_pkg.sv
// Shared encodings for the 6-digit display scanner: page modes, blank/off patterns
// and the "no field" edit selector.
package disp_pkg;

    typedef enum logic [1:0] {
        MODE_TIME  = 2'd0,
        MODE_DATE  = 2'd1,
        MODE_ALARM = 2'd2,
        MODE_BAD   = 2'd3
    } mode_e;

    localparam logic [7:0] SEG_BLANK  = 8'h00;
    localparam logic [5:0] COM_OFF    = 6'b111111;
    localparam logic [1:0] FIELD_NONE = 2'd3;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Decoder-side inputs and board-pin outputs of the display scanner.
// The master modport drives the segment sources; the slave modport is the scanner.
interface display_scan_ctrl_if;
    import disp_pkg::*;

    logic        modeNext_i;
    logic        editEn_i;
    logic [1:0]  editField_i;
    logic [47:0] inTimeSeg_i;
    logic [47:0] inDateSeg_i;
    logic [47:0] inAlarmSeg_i;
    logic [7:0]  outSeg_o;
    logic [5:0]  outCom_o;
    mode_e       outMode_o;

    modport master (
        output modeNext_i, editEn_i, editField_i,
        output inTimeSeg_i, inDateSeg_i, inAlarmSeg_i,
        input  outSeg_o, outCom_o, outMode_o
    );

    modport slave (
        input  modeNext_i, editEn_i, editField_i,
        input  inTimeSeg_i, inDateSeg_i, inAlarmSeg_i,
        output outSeg_o, outCom_o, outMode_o
    );

endinterface

// File: rtl/display_scan_ctrl_btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous push-button followed by a one-cycle
// rising-edge pulse; a held button yields a single pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexes one of three 6-digit segment pages onto a shared common-cathode bus,
// with page selection, edit-field blinking and an idle return to the time page.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter int TIMEOUT_FRAMES = 4096
) (
    input logic                clk,
    input logic                rst_n,
    display_scan_ctrl_if.slave bus
);

    localparam int PW = cnt_width(SCAN_DIV);
    localparam int BW = cnt_width(BLINK_FRAMES);
    localparam int TW = cnt_width(TIMEOUT_FRAMES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_FRAMES - 1);

    logic [PW-1:0] prescCnt_q, prescCnt_d;
    logic [2:0]    digitIdx_q, digitIdx_d;
    logic          started_q;
    logic [BW-1:0] blinkCnt_q;
    logic          blinkPhase_q;
    logic [TW-1:0] idleCnt_q;
    mode_e         modeState_q;
    logic [7:0]    segOut_q, segOut_d;
    logic [5:0]    comOut_q, comOut_d;

    logic          tick;
    logic          frameEnd;
    logic          modeEdge;
    logic          masked;
    logic [47:0]   page;
    logic [7:0]    pageBytes [6];

    btn_edge_sync u_mode_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (bus.modeNext_i),
        .rise_o (modeEdge)
    );

    // The slot after each tick is forced blank so the old digit never ghosts onto
    // the newly enabled common line; nothing shows until the first tick after reset.
    always_comb begin
        tick       = (prescCnt_q == PRESC_LAST);
        frameEnd   = tick && (digitIdx_q == 3'd5);
        prescCnt_d = tick ? '0 : prescCnt_q + 1'b1;
        digitIdx_d = digitIdx_q;
        if (tick) begin
            digitIdx_d = (digitIdx_q == 3'd5) ? 3'd0 : digitIdx_q + 3'd1;
        end
        case (modeState_q)
            MODE_TIME:  page = bus.inTimeSeg_i;
            MODE_DATE:  page = bus.inDateSeg_i;
            MODE_ALARM: page = bus.inAlarmSeg_i;
            default:    page = '0;
        endcase
        for (int i = 0; i < 6; i++) begin
            pageBytes[i] = page[47 - 8*i -: 8];
        end
        masked = bus.editEn_i && (bus.editField_i != FIELD_NONE) && blinkPhase_q
                 && (digitIdx_q[2:1] == bus.editField_i);
        segOut_d = SEG_BLANK;
        comOut_d = COM_OFF;
        if (!tick && started_q) begin
            comOut_d = ~(6'b100000 >> digitIdx_q);
            segOut_d = masked ? SEG_BLANK : pageBytes[digitIdx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescCnt_q   <= '0;
            digitIdx_q   <= '0;
            started_q    <= 1'b0;
            segOut_q     <= SEG_BLANK;
            comOut_q     <= COM_OFF;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
        end else begin
            prescCnt_q <= prescCnt_d;
            digitIdx_q <= digitIdx_d;
            started_q  <= started_q | tick;
            segOut_q   <= segOut_d;
            comOut_q   <= comOut_d;
            if (frameEnd) begin
                if (blinkCnt_q == BLINK_LAST) begin
                    blinkCnt_q   <= '0;
                    blinkPhase_q <= ~blinkPhase_q;
                end else begin
                    blinkCnt_q <= blinkCnt_q + 1'b1;
                end
            end
        end
    end

    // Page FSM: an accepted button edge always beats a coincident idle timeout,
    // and editing both freezes the page and holds the idle counter at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modeState_q <= MODE_TIME;
            idleCnt_q   <= '0;
        end else begin
            case (modeState_q)
                MODE_TIME: begin
                    idleCnt_q <= '0;
                    if (modeEdge && !bus.editEn_i) modeState_q <= MODE_DATE;
                end
                MODE_DATE, MODE_ALARM: begin
                    if (modeEdge && !bus.editEn_i) begin
                        modeState_q <= (modeState_q == MODE_DATE) ? MODE_ALARM : MODE_TIME;
                        idleCnt_q   <= '0;
                    end else if (bus.editEn_i) begin
                        idleCnt_q <= '0;
                    end else if (frameEnd) begin
                        if (idleCnt_q == IDLE_LAST) begin
                            modeState_q <= MODE_TIME;
                            idleCnt_q   <= '0;
                        end else begin
                            idleCnt_q <= idleCnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    modeState_q <= MODE_TIME;
                    idleCnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.outSeg_o  = segOut_q;
    assign bus.outCom_o  = comOut_q;
    assign bus.outMode_o = modeState_q;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes the segment patterns from the display decoder onto one shared 6-digit common-cathode 7-segment bus.
- Selects which page is shown (time, date or alarm) through a mode state machine.
- Blinks the field being edited and automatically returns to the time page after inactivity.
- Sits between the display decoder outputs and the board pins.

Parameters:
- SCAN_DIV, 1000: CLK cycles per digit slot (must be ≥ 2).
- BLINK_FRAMES, 64: full 6-digit frames per blink half-period.
- TIMEOUT_FRAMES, 4096: idle frames in DATE/ALARM before returning to TIME.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  asynchronous, active-low reset.
- MODE_NEXT  in  1  raw push-button level; active-high; asynchronous to CLK.
- EDIT_EN  in  1  high while the clock-setting logic is editing.
- EDIT_FIELD  in  2  field to blink: 0 = digits 0-1, 1 = digits 2-3, 2 = digits 4-5, 3 = none.
- IN_TIME_SEG  in  48  {H10,H1,M10,M1,S10,S1} segment patterns.
- IN_DATE_SEG  in  48  {Y10,Y1,MT10,MT1,D10,D1} segment patterns.
- IN_ALARM_SEG  in  48  {AH10,AH1,AM10,AM1,AS10,AS1} segment patterns.
- OUT_SEG  out  8  segment drive, active-high; 8'h00 means blank.
- OUT_COM  out  6  digit enables, active-low one-hot; all-ones means none enabled.
- OUT_MODE  out  2  current page: 0 TIME, 1 DATE, 2 ALARM.

Behaviour:
- Clocking and reset: single CLK; RESETN is asynchronous and active-low.
- Reset values: OUT_SEG=8'h00, OUT_COM=6'b111111, OUT_MODE=TIME, digit index=0, prescaler=0, blink phase=0 (visible), frame/timeout/blink counters=0, synchroniser flops=0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. The cycle in which it equals SCAN_DIV-1 is the digit tick.
- Digit slot, cycle 1 (cycle after a tick):
  - digit index advances k -> k+1, wrapping 5 -> 0;
  - OUT_COM=6'b111111 and OUT_SEG=8'h00 (one-cycle anti-ghost blank).
- Digit slot, cycle 2 through the end of the slot:
  - OUT_COM = ~(6'b100000 >> k);
  - OUT_SEG = selected page bits [47-8k -: 8], or 8'h00 if the digit is blink-masked.
  - Digit 0 is the leftmost digit (H10/Y10/AH10).
- All outputs are registered; nothing is combinational from input to output.
- Segment source is sampled each cycle. A page change takes effect on the next displayed digit; the scan is never restarted.
- Frame end: the tick at which the index wraps 5 -> 0.
- MODE_NEXT input path:
  - 2-flop synchroniser, then a rising-edge detect;
  - edge pulse appears 3 cycles after the input rises;
  - a held button yields exactly one edge.
- Mode FSM, with edge = MODE_NEXT edge pulse:
  - TIME --edge--> DATE --edge--> ALARM --edge--> TIME.
  - Edges are ignored while EDIT_EN=1; the page is frozen.
  - Encoding 3 is unreachable. If it is ever present, it goes to TIME on the next cycle.
- Timeout:
  - The timeout counter increments at each frame end while in DATE or ALARM with EDIT_EN=0.
  - It clears on any accepted edge, whenever EDIT_EN=1, or while in TIME.
  - When it reaches TIMEOUT_FRAMES, the FSM goes to TIME and the counter clears.
  - If an edge and the timeout occur in the same cycle, the edge wins.
- Blink:
  - The blink counter counts frame ends and toggles the blink phase every BLINK_FRAMES frames.
  - It runs freely regardless of EDIT_EN.
  - Mask condition: EDIT_EN=1, EDIT_FIELD != 3, blink phase = 1, and k in {2·EDIT_FIELD, 2·EDIT_FIELD+1}.
  - When EDIT_EN falls, masking stops immediately at the next output register update.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No wrap beyond the terminal value.
- Reset mid-operation: all state returns to reset values asynchronously. The first digit shown after release is k=1, after one prescaler period plus the blank cycle.

Decomposition:
- Package disp_pkg holds:
  - mode encodings MODE_TIME=2'd0, MODE_DATE=2'd1, MODE_ALARM=2'd2;
  - SEG_BLANK=8'h00 and COM_OFF=6'b111111;
  - field encoding FIELD_NONE=2'd3.
- One natural sub-module: btn_edge_sync (2-flop synchroniser plus rising-edge pulse), reusable for other board buttons.
- The scan/mode/blink logic stays in one module.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2, TIMEOUT_FRAMES=5):
- Release reset with IN_TIME_SEG=48'h3F_06_5B_4F_66_6D:
  - OUT_COM=111111 and OUT_SEG=00 for 5 cycles;
  - then COM=101111 with SEG=06;
  - each slot is 4 cycles with the first cycle blank;
  - the sequence wraps to COM=011111 with SEG=3F.
- Pulse MODE_NEXT high for 10 cycles:
  - OUT_MODE=1 exactly 3 cycles after the rise;
  - only one increment;
  - the next digit shows IN_DATE_SEG bytes.
- Press MODE_NEXT twice more:
  - OUT_MODE goes 2, then 0;
  - alarm bytes are shown while in mode 2.
- In DATE, hold all inputs idle: OUT_MODE returns to 0 at the 5th frame end (5×24 cycles).
- Repeat in DATE with EDIT_EN=1: OUT_MODE stays 1 indefinitely, and MODE_NEXT presses are ignored.
- EDIT_EN=1, EDIT_FIELD=1:
  - digits 2 and 3 read SEG=00 for frames 2-3, visible in frames 0-1 and 4-5;
  - digits 0, 1, 4 and 5 are always visible;
  - with EDIT_FIELD=3, no digit is ever blanked.
- Assert RESETN low mid-slot with COM=110111: outputs go to 111111/00 within the same cycle with no clock edge, and OUT_MODE=0.
